// File: rtl/sv_matmul_if.sv
// Handshake and operand/result bundle between a score producer and sv_matmul.
// The master drives start and operands; the slave (sv_matmul) returns busy, done and the context vector.
interface sv_matmul_if #(
    parameter int HEAD_DIM = 4,
    parameter int SEQ_LEN  = 3,
    parameter int DW       = 4,
    parameter int OW       = 2 * DW
) ();
    logic                                  start;
    logic [SEQ_LEN-1:0][2*DW-1:0]          score;
    logic [SEQ_LEN-1:0][HEAD_DIM-1:0][DW-1:0] v_mat;
    logic                                  busy;
    logic                                  done;
    logic [HEAD_DIM-1:0][OW-1:0]           out_vec;

    modport master (output start, score, v_mat, input busy, done, out_vec);
    modport slave  (input start, score, v_mat, output busy, done, out_vec);
endinterface

// File: rtl/sv_matmul.sv
// Attention context vector: out_vec[d] = sum_s score[s]*v_mat[s][d], one V row per cycle.
// Optional SV_MATMUL_SAT_EN clamps each result to OW bits instead of wrapping.
module sv_matmul #(
    parameter int HEAD_DIM = 4,
    parameter int SEQ_LEN  = 3,
    parameter int DW       = 4,
    parameter int OW       = 2 * DW
) (
    input  logic        clk,
    input  logic        rst,
    sv_matmul_if.slave  bus
);
    localparam int PW    = 3 * DW;
    localparam int ACC_W = 3 * DW + $clog2(SEQ_LEN) + 1;
    localparam int CNT_W = (SEQ_LEN > 1) ? $clog2(SEQ_LEN) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SEQ_LEN - 1);
`ifdef SV_MATMUL_SAT_EN
    localparam logic signed [ACC_W-1:0] OUT_MAX = ACC_W'((64'sd1 <<< (OW - 1)) - 64'sd1);
    localparam logic signed [ACC_W-1:0] OUT_MIN = ACC_W'(-(64'sd1 <<< (OW - 1)));
`endif

    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;

    state_t                                   state_q, state_d;
    logic                                     busy_q, busy_d;
    logic                                     done_q, done_d;
    logic [CNT_W-1:0]                         cnt_q, cnt_d;
    logic [SEQ_LEN-1:0][2*DW-1:0]             score_q, score_d;
    logic [SEQ_LEN-1:0][HEAD_DIM-1:0][DW-1:0] v_q, v_d;
    logic signed [ACC_W-1:0]                  acc_q [HEAD_DIM];
    logic signed [ACC_W-1:0]                  acc_d [HEAD_DIM];
    logic [HEAD_DIM-1:0][OW-1:0]              out_q, out_d;
    logic signed [PW-1:0]                     prod_s [HEAD_DIM];
    logic                                     start_ok_s;

    function automatic logic [OW-1:0] fit_out(input logic signed [ACC_W-1:0] a);
`ifdef SV_MATMUL_SAT_EN
        if (a > OUT_MAX) begin
            fit_out = OUT_MAX[OW-1:0];
        end else if (a < OUT_MIN) begin
            fit_out = OUT_MIN[OW-1:0];
        end else begin
            fit_out = OW'(a);
        end
`else
        fit_out = OW'(a);
`endif
    endfunction

    assign start_ok_s = bus.start && (state_q != RUN);

    // State and datapath registers; rst overrides everything.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            cnt_q   <= '0;
            score_q <= '0;
            v_q     <= '0;
            out_q   <= '0;
            for (int d = 0; d < HEAD_DIM; d++) acc_q[d] <= '0;
        end else begin
            state_q <= state_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            cnt_q   <= cnt_d;
            score_q <= score_d;
            v_q     <= v_d;
            out_q   <= out_d;
            for (int d = 0; d < HEAD_DIM; d++) acc_q[d] <= acc_d[d];
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = bus.start ? RUN : IDLE;
            RUN:     state_d = (cnt_q == CNT_LAST) ? DONE : RUN;
            DONE:    state_d = bus.start ? RUN : IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Registered status outputs; done follows the single DONE cycle.
    always_comb begin
        busy_d = (state_d == RUN);
        done_d = (state_q == DONE);
    end

    // One product per output lane from the current V row; operands sign-extended first.
    always_comb begin
        for (int d = 0; d < HEAD_DIM; d++) begin
            prod_s[d] = PW'($signed(score_q[cnt_q])) * PW'($signed(v_q[cnt_q][d]));
        end
    end

    // Operand capture, accumulation and result publication.
    always_comb begin
        cnt_d   = cnt_q;
        score_d = score_q;
        v_d     = v_q;
        out_d   = out_q;
        for (int d = 0; d < HEAD_DIM; d++) acc_d[d] = acc_q[d];
        if (start_ok_s) begin
            cnt_d   = '0;
            score_d = bus.score;
            v_d     = bus.v_mat;
            for (int d = 0; d < HEAD_DIM; d++) acc_d[d] = '0;
        end else if (state_q == RUN) begin
            cnt_d = (cnt_q == CNT_LAST) ? '0 : cnt_q + CNT_W'(1);
            for (int d = 0; d < HEAD_DIM; d++) acc_d[d] = acc_q[d] + ACC_W'(prod_s[d]);
        end else begin
            cnt_d = cnt_q;
        end
        // Publish from the pre-clear accumulators even when a new start lands in DONE.
        if (state_q == DONE) begin
            for (int d = 0; d < HEAD_DIM; d++) out_d[d] = fit_out(acc_q[d]);
        end else begin
            out_d = out_q;
        end
    end

    assign bus.busy    = busy_q;
    assign bus.done    = done_q;
    assign bus.out_vec = out_q;
endmodule

// File: tb/tb_sv_matmul.sv
// Directed bench for sv_matmul with a scoreboard of expected context vectors.
module tb_sv_matmul;
    typedef int sc_t[3];
    typedef int vm_t[3][4];

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;
    logic [31:0] exp_q[$];

    always #5 clk = ~clk;

    sv_matmul_if #(.HEAD_DIM(4), .SEQ_LEN(3), .DW(4), .OW(8)) bus ();
    sv_matmul_if #(.HEAD_DIM(4), .SEQ_LEN(1), .DW(4), .OW(8)) bus1 ();

    sv_matmul #(.HEAD_DIM(4), .SEQ_LEN(3), .DW(4), .OW(8)) dut (.clk(clk), .rst(rst), .bus(bus));
    sv_matmul #(.HEAD_DIM(4), .SEQ_LEN(1), .DW(4), .OW(8)) dut1 (.clk(clk), .rst(rst), .bus(bus1));

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    function automatic logic [31:0] model(input sc_t sc, input vm_t vm);
        logic [31:0] r;
        int acc;
        r = 32'd0;
        for (int d = 0; d < 4; d++) begin
            acc = 0;
            for (int s = 0; s < 3; s++) acc += sc[s] * vm[s][d];
`ifdef SV_MATMUL_SAT_EN
            if (acc > 127) acc = 127;
            if (acc < -128) acc = -128;
`endif
            r[d*8 +: 8] = 8'(acc);
        end
        return r;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input sc_t sc, input vm_t vm);
        for (int s = 0; s < 3; s++) begin
            bus.score[s] = 8'(sc[s]);
            for (int d = 0; d < 4; d++) bus.v_mat[s][d] = 4'(vm[s][d]);
        end
    endtask

    // Pulse start for one cycle; returns at the falling edge after the sampling edge.
    task automatic run_start(input sc_t sc, input vm_t vm);
        @(negedge clk);
        drive(sc, vm);
        bus.start = 1'b1;
        exp_q.push_back(model(sc, vm));
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    task automatic wait_done(input string tag, output int k);
        k = 0;
        do begin
            @(posedge clk);
            @(negedge clk);
            k++;
        end while (!bus.done && k < 20);
        check({tag, "_seen"}, 64'(bus.done), 64'd1);
    endtask

    task automatic check_result(input string tag);
        if (exp_q.size() == 0) begin
            check({tag, "_sb_empty"}, 64'd1, 64'd0);
        end else begin
            check(tag, 64'(bus.out_vec), 64'(exp_q.pop_front()));
        end
    endtask

    initial begin
        sc_t sc1 = '{4, 6, 10};
        vm_t v1  = '{'{1, 0, 1, 0}, '{0, 1, 0, 1}, '{1, 1, 1, 1}};
        sc_t sc2 = '{-1, 2, -3};
        vm_t v2  = '{'{1, -2, 3, -4}, '{1, -2, 3, -4}, '{1, -2, 3, -4}};
        sc_t sc3 = '{127, 127, 127};
        vm_t v3  = '{'{7, 7, 7, 7}, '{7, 7, 7, 7}, '{7, 7, 7, 7}};
        logic [31:0] exp_a;
        logic [31:0] sat_exp;
        int k;
        int k2;
        int dones;
        logic hold_bad;

        bus.start  = 1'b0;
        bus.score  = '0;
        bus.v_mat  = '0;
        bus1.start = 1'b0;
        bus1.score = '0;
        bus1.v_mat = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check("rst_busy", 64'(bus.busy), 64'd0);
        check("rst_done", 64'(bus.done), 64'd0);
        check("rst_out", 64'(bus.out_vec), 64'd0);
        check("rst_out1", 64'(bus1.out_vec), 64'd0);

        // 1: basic result and start->done latency of SEQ_LEN+1 edges
        run_start(sc1, v1);
        check("t1_busy", 64'(bus.busy), 64'd1);
        wait_done("t1_done", k);
        check("t1_latency", 64'(k), 64'd4);
        check("t1_busy_at_done", 64'(bus.busy), 64'd0);
        check("t1_const", 64'(bus.out_vec), 64'h10_0E_10_0E);
        check_result("t1_out");
        @(posedge clk);
        @(negedge clk);
        check("t1_done_one_cycle", 64'(bus.done), 64'd0);
        check("t1_hold", 64'(bus.out_vec), 64'h10_0E_10_0E);

        // 2: signed scores and V elements
        run_start(sc2, v2);
        wait_done("t2_done", k);
        check("t2_const", 64'(bus.out_vec), 64'h08_FA_04_FE);
        check_result("t2_out");

        // 3: result exceeding OW bits
        run_start(sc3, v3);
        wait_done("t3_done", k);
`ifdef SV_MATMUL_SAT_EN
        sat_exp = 32'h7F7F7F7F;
`else
        sat_exp = 32'h6B6B6B6B;
`endif
        check("t3_const", 64'(bus.out_vec), 64'(sat_exp));
        check_result("t3_out");

        // 4: start during RUN is ignored; later input changes do not leak in
        run_start(sc1, v1);
        drive(sc2, v2);
        bus.start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0;
        bus.score = 24'($urandom);
        bus.v_mat = 48'({$urandom, $urandom});
        wait_done("t4_done", k);
        check("t4_latency", 64'(k), 64'd3);
        check_result("t4_out");

        // 5: rst on the second RUN cycle aborts with no done
        run_start(sc2, v2);
        void'(exp_q.pop_back());
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check("t5_busy", 64'(bus.busy), 64'd0);
        check("t5_done", 64'(bus.done), 64'd0);
        check("t5_out", 64'(bus.out_vec), 64'd0);
        dones = 0;
        repeat (8) begin
            @(posedge clk);
            @(negedge clk);
            if (bus.done) dones++;
        end
        check("t5_no_done", 64'(dones), 64'd0);
        run_start(sc2, v2);
        wait_done("t5_rerun_done", k);
        check("t5_rerun_latency", 64'(k), 64'd4);
        check_result("t5_rerun_out");

        // 6: start held across DONE gives a back-to-back run
        exp_a = model(sc1, v1);
        @(negedge clk);
        drive(sc1, v1);
        bus.start = 1'b1;
        exp_q.push_back(exp_a);
        @(posedge clk);
        @(negedge clk);
        drive(sc3, v3);
        exp_q.push_back(model(sc3, v3));
        wait_done("t6_first_done", k);
        bus.start = 1'b0;
        check("t6_first_latency", 64'(k), 64'd4);
        check("t6_rerun_busy", 64'(bus.busy), 64'd1);
        check_result("t6_first_out");
        k2 = 0;
        hold_bad = 1'b0;
        do begin
            @(posedge clk);
            @(negedge clk);
            k2++;
            if (!bus.done && bus.out_vec !== exp_a) hold_bad = 1'b1;
        end while (!bus.done && k2 < 20);
        check("t6_spacing", 64'(k2), 64'd4);
        check("t6_hold", 64'(hold_bad), 64'd0);
        check_result("t6_second_out");

        // 7: SEQ_LEN=1 instance, single RUN cycle
        @(negedge clk);
        bus1.score[0] = 8'd5;
        bus1.v_mat[0][0] = 4'sd1;
        bus1.v_mat[0][1] = -4'sd1;
        bus1.v_mat[0][2] = 4'sd2;
        bus1.v_mat[0][3] = -4'sd2;
        bus1.start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus1.start = 1'b0;
        check("t7_busy", 64'(bus1.busy), 64'd1);
        @(posedge clk);
        @(negedge clk);
        check("t7_busy_drop", 64'(bus1.busy), 64'd0);
        check("t7_no_early_done", 64'(bus1.done), 64'd0);
        @(posedge clk);
        @(negedge clk);
        check("t7_done", 64'(bus1.done), 64'd1);
        check("t7_out", 64'(bus1.out_vec), 64'hF6_0A_FB_05);

        check("sb_drained", 64'(exp_q.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
